// File: rtl/ase_hssi_tx_frame_capture.sv
// ase_hssi_tx_frame_capture
//   Store-and-forward sink for the AFU-to-host HSSI TX stream. Each accepted AXI-S beat is queued
//   unchanged in a beat FIFO. The frame is measured and checked as it arrives. When the frame
//   closes, a descriptor {len, tuser, err} is queued for the host. The host drains both queues
//   independently through valid/ready ports.
// Ports
//   clk_i, reset_i              single clock, synchronous active-high reset
//   s_t*_i / s_tready_o         AXI-S TX beats from the AFU
//   d_valid_o, d_ready_i, d_*_o stored beats to the host
//   desc_*                      per-frame descriptors to the host
//   stat_frames_o               frames completed (wraps)
//   stat_err_frames_o           frames completed with an error (wraps)
module ase_hssi_tx_frame_capture #(
  parameter int unsigned TDATA_WIDTH     = 64,
  parameter int unsigned TUSER_WIDTH     = 1,
  parameter int unsigned DATA_FIFO_DEPTH = 512,
  parameter int unsigned DESC_FIFO_DEPTH = 16,
  parameter int unsigned MAX_FRAME_BYTES = 9600
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     s_tvalid_i,
  output logic                     s_tready_o,
  input  logic [TDATA_WIDTH-1:0]   s_tdata_i,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep_i,
  input  logic                     s_tlast_i,
  input  logic [TUSER_WIDTH-1:0]   s_tuser_i,
  output logic                     d_valid_o,
  input  logic                     d_ready_i,
  output logic [TDATA_WIDTH-1:0]   d_data_o,
  output logic [TDATA_WIDTH/8-1:0] d_keep_o,
  output logic                     d_last_o,
  output logic                     desc_valid_o,
  input  logic                     desc_ready_i,
  output logic [15:0]              desc_len_o,
  output logic [TUSER_WIDTH-1:0]   desc_tuser_o,
  output logic                     desc_err_o,
  output logic [31:0]              stat_frames_o,
  output logic [31:0]              stat_err_frames_o
);

  localparam int unsigned KeepW  = TDATA_WIDTH / 8;
  localparam int unsigned DataAw = $clog2(DATA_FIFO_DEPTH);
  localparam int unsigned DescAw = $clog2(DESC_FIFO_DEPTH);
  localparam int unsigned DataEw = TDATA_WIDTH + KeepW + 1;
  localparam int unsigned DescEw = 16 + TUSER_WIDTH + 1;

  typedef enum logic [0:0] {StIdle, StInFrame} state_e;

  // Frame tracking state
  state_e                 state_q;
  logic [16:0]            acc_q;
  logic                   err_q;
  logic [TUSER_WIDTH-1:0] tuser_q;
  logic [31:0]            stat_frames_q, stat_err_frames_q;

  // FIFO state
  logic [DataEw-1:0] data_mem [DATA_FIFO_DEPTH];
  logic [DataAw-1:0] data_wr_q, data_rd_q;
  logic [DataAw:0]   data_cnt_q, data_cnt_d;
  logic              data_full_q;
  logic [DescEw-1:0] desc_mem [DESC_FIFO_DEPTH];
  logic [DescAw-1:0] desc_wr_q, desc_rd_q;
  logic [DescAw:0]   desc_cnt_q, desc_cnt_d;
  logic              desc_full_q;

  logic accept, frame_close, data_pop, desc_pop;

  // Full flags are registered and not bypassed by a same-cycle pop.
  assign s_tready_o  = !reset_i && !data_full_q && !desc_full_q;
  assign accept      = s_tvalid_i && s_tready_o;
  assign frame_close = accept && s_tlast_i;

  // ---------------------------------------------------------------------------------------------
  // Beat measurement and checks
  // ---------------------------------------------------------------------------------------------
  logic [16:0]            keep_cnt;
  logic [17:0]            acc_sum;
  logic [16:0]            acc_next;
  logic                   keep_contig, beat_err, sat_err, len_err, err_next, frame_err;
  logic [15:0]            frame_len;
  logic [TUSER_WIDTH-1:0] frame_tuser;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < int'(KeepW); i++) begin
      keep_cnt = keep_cnt + 17'(s_tkeep_i[i]);
    end
  end

  // LSB-contiguous ones: adding 1 carries through the run and clears every original bit.
  assign keep_contig = (s_tkeep_i & (s_tkeep_i + {{(KeepW-1){1'b0}}, 1'b1})) == '0;
  assign beat_err    = s_tlast_i ? ((s_tkeep_i == '0) || !keep_contig) : (s_tkeep_i != '1);

  // The accumulator saturates at its own width so it cannot wrap on very long frames.
  assign acc_sum     = {1'b0, acc_q} + {1'b0, keep_cnt};
  assign acc_next    = acc_sum[17] ? 17'h1FFFF : acc_sum[16:0];
  assign sat_err     = acc_next[16];
  assign len_err     = acc_next > 17'(MAX_FRAME_BYTES);
  assign err_next    = err_q | beat_err | sat_err;
  assign frame_err   = err_next | len_err;
  assign frame_len   = acc_next[16] ? 16'hFFFF : acc_next[15:0];
  // A one-beat frame closes in IDLE, so its tuser comes straight from the bus.
  assign frame_tuser = (state_q == StIdle) ? s_tuser_i : tuser_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= StIdle;
      acc_q             <= '0;
      err_q             <= 1'b0;
      tuser_q           <= '0;
      stat_frames_q     <= '0;
      stat_err_frames_q <= '0;
    end else if (accept) begin
      if (s_tlast_i) begin
        state_q       <= StIdle;
        acc_q         <= '0;
        err_q         <= 1'b0;
        stat_frames_q <= stat_frames_q + 32'd1;
        if (frame_err) begin
          stat_err_frames_q <= stat_err_frames_q + 32'd1;
        end
      end else begin
        if (state_q == StIdle) begin
          tuser_q <= s_tuser_i;
        end
        state_q <= StInFrame;
        acc_q   <= acc_next;
        err_q   <= err_next;
      end
    end
  end

  assign stat_frames_o     = stat_frames_q;
  assign stat_err_frames_o = stat_err_frames_q;

  // ---------------------------------------------------------------------------------------------
  // Beat FIFO
  // ---------------------------------------------------------------------------------------------
  assign d_valid_o = data_cnt_q != '0;
  assign data_pop  = d_valid_o && d_ready_i;

  always_comb begin
    data_cnt_d = data_cnt_q;
    if (accept && !data_pop) begin
      data_cnt_d = data_cnt_q + (DataAw+1)'(1);
    end else if (!accept && data_pop) begin
      data_cnt_d = data_cnt_q - (DataAw+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_mem[data_wr_q] <= {s_tlast_i, s_tkeep_i, s_tdata_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_wr_q   <= '0;
      data_rd_q   <= '0;
      data_cnt_q  <= '0;
      data_full_q <= 1'b0;
    end else begin
      if (accept) begin
        data_wr_q <= data_wr_q + DataAw'(1);
      end
      if (data_pop) begin
        data_rd_q <= data_rd_q + DataAw'(1);
      end
      data_cnt_q  <= data_cnt_d;
      data_full_q <= data_cnt_d == (DataAw+1)'(DATA_FIFO_DEPTH);
    end
  end

  // Outputs read as zero while empty so the reset and idle values are defined.
  assign {d_last_o, d_keep_o, d_data_o} = d_valid_o ? data_mem[data_rd_q] : '0;

  // ---------------------------------------------------------------------------------------------
  // Descriptor FIFO. No beat is accepted while it is full, so a closing frame always has space.
  // ---------------------------------------------------------------------------------------------
  assign desc_valid_o = desc_cnt_q != '0;
  assign desc_pop     = desc_valid_o && desc_ready_i;

  always_comb begin
    desc_cnt_d = desc_cnt_q;
    if (frame_close && !desc_pop) begin
      desc_cnt_d = desc_cnt_q + (DescAw+1)'(1);
    end else if (!frame_close && desc_pop) begin
      desc_cnt_d = desc_cnt_q - (DescAw+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (frame_close) begin
      desc_mem[desc_wr_q] <= {frame_len, frame_tuser, frame_err};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      desc_wr_q   <= '0;
      desc_rd_q   <= '0;
      desc_cnt_q  <= '0;
      desc_full_q <= 1'b0;
    end else begin
      if (frame_close) begin
        desc_wr_q <= desc_wr_q + DescAw'(1);
      end
      if (desc_pop) begin
        desc_rd_q <= desc_rd_q + DescAw'(1);
      end
      desc_cnt_q  <= desc_cnt_d;
      desc_full_q <= desc_cnt_d == (DescAw+1)'(DESC_FIFO_DEPTH);
    end
  end

  assign {desc_len_o, desc_tuser_o, desc_err_o} = desc_valid_o ? desc_mem[desc_rd_q] : '0;

endmodule

// File: tb/tb_ase_hssi_tx_frame_capture.sv
// Directed bench for ase_hssi_tx_frame_capture: hand-computed descriptors, a beat scoreboard fed
// from the stimulus itself, and explicit checks of reset, latency, throughput and full boundaries.
module tb_ase_hssi_tx_frame_capture;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [0:0]    s_tuser;
  logic          d_valid, d_ready, d_last;
  logic [DW-1:0] d_data;
  logic [KW-1:0] d_keep;
  logic          desc_valid, desc_ready, desc_err;
  logic [15:0]   desc_len;
  logic [0:0]    desc_tuser;
  logic [31:0]   stat_frames, stat_err_frames;

  ase_hssi_tx_frame_capture dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .s_tvalid_i        (s_tvalid),
    .s_tready_o        (s_tready),
    .s_tdata_i         (s_tdata),
    .s_tkeep_i         (s_tkeep),
    .s_tlast_i         (s_tlast),
    .s_tuser_i         (s_tuser),
    .d_valid_o         (d_valid),
    .d_ready_i         (d_ready),
    .d_data_o          (d_data),
    .d_keep_o          (d_keep),
    .d_last_o          (d_last),
    .desc_valid_o      (desc_valid),
    .desc_ready_i      (desc_ready),
    .desc_len_o        (desc_len),
    .desc_tuser_o      (desc_tuser),
    .desc_err_o        (desc_err),
    .stat_frames_o     (stat_frames),
    .stat_err_frames_o (stat_err_frames)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW+KW:0] exp_beats [$];  // {last, keep, data}
  logic [17:0]    exp_desc  [$];  // {len, tuser, err}
  int             d_mode = 0;     // 0: d_ready low, 1: high, 2: toggle each cycle

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // d_ready has a single driver so the toggle pattern cannot race the main sequence.
  initial begin
    d_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (d_mode)
        0:       d_ready = 1'b0;
        1:       d_ready = 1'b1;
        default: d_ready = ~d_ready;
      endcase
    end
  end

  // Beat scoreboard: a pop happens on the next posedge when valid && ready at this negedge.
  always @(negedge clk) begin
    if (reset === 1'b0 && d_valid && d_ready) begin
      if (exp_beats.size() == 0) begin
        check_eq("d_unexpected_beat", d_data, 64'hDEAD);
      end else begin
        logic [DW+KW:0] e;
        e = exp_beats.pop_front();
        check_eq("d_data", d_data, e[DW-1:0]);
        check_eq("d_keep", d_keep, e[DW+KW-1:DW]);
        check_eq("d_last", d_last, e[DW+KW]);
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && desc_valid && desc_ready) begin
      if (exp_desc.size() == 0) begin
        check_eq("desc_unexpected", desc_len, 64'hDEAD);
      end else begin
        logic [17:0] e;
        e = exp_desc.pop_front();
        check_eq("desc_len", desc_len, e[17:2]);
        check_eq("desc_tuser", desc_tuser, e[1]);
        check_eq("desc_err", desc_err, e[0]);
      end
    end
  end

  // Present one beat at posedge+1, hold until accepted, return at posedge+1 after acceptance.
  task automatic drive_beat(input logic [63:0] data, input logic [7:0] keep, input logic last,
                            input logic tuser, output int stalls);
    bit done;
    done     = 1'b0;
    stalls   = 0;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tuser  = tuser;
    while (!done) begin
      @(negedge clk);
      if (s_tready) begin
        exp_beats.push_back({last, keep, data});
        done = 1'b1;
      end else begin
        stalls++;
        if (stalls > 200) begin
          check_eq("accept_timeout", 64'(stalls), 64'd0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000 && (exp_beats.size() != 0 || exp_desc.size() != 0); i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("drain_beats", 64'(exp_beats.size()), 64'd0);
    check_eq("drain_desc", 64'(exp_desc.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    int tot;
    reset      = 1'b1;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tlast    = 1'b0;
    s_tuser    = '0;
    desc_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tready", s_tready, 0);
    check_eq("rst_d_valid", d_valid, 0);
    check_eq("rst_desc_valid", desc_valid, 0);
    check_eq("rst_desc_len", desc_len, 0);
    check_eq("rst_d_data", d_data, 0);
    check_eq("rst_stat_frames", stat_frames, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("tready_after_reset", s_tready, 1);

    // 3-beat frame: 8+8+4 = 20 bytes, tuser taken from the first beat only
    d_mode     = 1;
    desc_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_desc.push_back({16'd20, 1'b1, 1'b0});
    drive_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b1, st);
    drive_beat(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 1'b0, st);
    drive_beat(64'h0000_0000_9999_AAAA, 8'h0F, 1'b1, 1'b0, st);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("t1_stat_frames", stat_frames, 1);
    check_eq("t1_stat_err", stat_err_frames, 0);
    wait_drain();

    // One-beat frame: descriptor visible one cycle after acceptance
    exp_desc.push_back({16'd1, 1'b0, 1'b0});
    drive_beat(64'h0000_0000_0000_00C3, 8'h01, 1'b1, 1'b0, st);
    @(negedge clk);
    check_eq("lat_desc_valid", desc_valid, 1);
    check_eq("lat_desc_len", desc_len, 1);
    @(posedge clk);
    #1;
    // Back-to-back one-beat frames, lengths 1..4
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] k;
      k = 8'((1 << (i + 1)) - 1);
      exp_desc.push_back({16'(i + 1), 1'b0, 1'b0});
      drive_beat(64'hB2B0_0000_0000_0000 | 64'(i), k, 1'b1, 1'b0, st);
      tot += st;
    end
    check_eq("b2b_stalls", 64'(tot), 0);
    wait_drain();

    // Error frame: middle keep 7F, last keep 05 (non-contiguous); 8+7+2 = 17 bytes
    exp_desc.push_back({16'd17, 1'b0, 1'b1});
    drive_beat(64'hE000_0000_0000_0001, 8'hFF, 1'b0, 1'b0, st);
    drive_beat(64'hE000_0000_0000_0002, 8'h7F, 1'b0, 1'b0, st);
    drive_beat(64'hE000_0000_0000_0003, 8'h05, 1'b1, 1'b0, st);
    wait_drain();
    check_eq("t3_stat_err", stat_err_frames, 1);
    check_eq("t3_stat_frames", stat_frames, 7);

    // Oversize frame: 1201 x 8 = 9608 bytes with d_ready toggling, beat FIFO must fill
    d_mode = 2;
    exp_desc.push_back({16'd9608, 1'b0, 1'b1});
    tot = 0;
    for (int i = 0; i < 1201; i++) begin
      drive_beat(64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF, i == 1200, 1'b0, st);
      tot += st;
    end
    check_eq("big_fifo_stalled", tot > 0, 1);
    d_mode = 1;
    wait_drain();
    check_eq("big_stat_err", stat_err_frames, 2);
    check_eq("big_stat_frames", stat_frames, 8);

    // Descriptor FIFO full after 16 frames; one pop reopens s_tready
    desc_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_desc.push_back({16'd1, 1'b0, 1'b0});
      drive_beat(64'hD000_0000_0000_0000 | 64'(i), 8'h01, 1'b1, 1'b0, st);
    end
    @(negedge clk);
    check_eq("descfull_tready", s_tready, 0);
    @(posedge clk);
    #1;
    desc_ready = 1'b1;
    @(posedge clk);
    #1;
    desc_ready = 1'b0;
    @(negedge clk);
    check_eq("descpop_tready", s_tready, 1);
    @(posedge clk);
    #1;
    desc_ready = 1'b1;
    wait_drain();
    check_eq("descfull_stat_frames", stat_frames, 24);

    // Reset during beat 2 of 4: everything flushed, FSM back to IDLE
    d_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    drive_beat(64'hF000_0000_0000_0001, 8'hFF, 1'b0, 1'b1, st);
    s_tvalid = 1'b1;
    s_tdata  = 64'hF000_0000_0000_0002;
    s_tkeep  = 8'hFF;
    s_tlast  = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    s_tvalid = 1'b0;
    exp_beats.delete();
    @(negedge clk);
    check_eq("midrst_d_valid", d_valid, 0);
    check_eq("midrst_desc_valid", desc_valid, 0);
    check_eq("midrst_stat_frames", stat_frames, 0);
    check_eq("midrst_stat_err", stat_err_frames, 0);
    check_eq("midrst_tready", s_tready, 1);
    d_mode = 1;
    @(posedge clk);
    #1;
    exp_desc.push_back({16'd10, 1'b1, 1'b0});
    drive_beat(64'h0C1E_A000_0000_0001, 8'hFF, 1'b0, 1'b1, st);
    drive_beat(64'h0C1E_A000_0000_0002, 8'h03, 1'b1, 1'b0, st);
    wait_drain();
    check_eq("clean_stat_frames", stat_frames, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
